// File: rtl/histo_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer and bin-RAM arbiter for the greyscale histogram: accumulate, optional
// cumulative sweep in blanking (macro HISTO_CUM_EN), then serve display reads.
module histo_ctrl #(
    parameter int unsigned BIN_AW = 8,
    parameter int unsigned CNT_W  = 20
) (
    input  logic              iPclk,
    input  logic              iRST_N,
    input  logic              iFval,
    input  logic              iDval,
    input  logic [BIN_AW-1:0] iGrey,
    output logic [BIN_AW:0]   oRAddr,
    input  logic [CNT_W-1:0]  iRData,
    output logic [BIN_AW:0]   oWAddr,
    output logic [CNT_W-1:0]  oWData,
    output logic              oWe,
    input  logic              iRd_req,
    input  logic              iRd_cum,
    input  logic [BIN_AW-1:0] iRd_bin,
    output logic              oRd_valid,
    output logic [CNT_W-1:0]  oRd_data,
    output logic              oHist_ready,
    output logic [CNT_W-1:0]  oTotal
);

    localparam int unsigned Bins = 2 ** BIN_AW;
    localparam logic [CNT_W-1:0] CntMax = '1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StCum   = 2'd2;
    localparam logic [1:0] StReady = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              fval_q;
    logic [Bins-1:0]   touched_q, touched_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              s1_vld_q, s1_vld_d;
    logic [BIN_AW-1:0] s1_bin_q, s1_bin_d;
    logic              fwd_vld_q, fwd_vld_d;
    logic [CNT_W-1:0]  fwd_data_q, fwd_data_d;
    logic              rd_vld_q, rd_vld_d;
    logic [BIN_AW-1:0] rd_bin_q, rd_bin_d;
    logic              rd_cum_q, rd_cum_d;

    logic              fval_rise, fval_fall, s0_go, rd_cum_sel;
    logic [CNT_W-1:0]  s1_src, s1_wdata;

    assign fval_rise = iFval & ~fval_q;
    assign fval_fall = ~iFval & fval_q;
    // Pixels on the falling-edge cycle are dropped so the last write lands before any sweep.
    assign s0_go     = (state_q == StAccum) & iDval & ~fval_fall;

    // Forwarded value covers the write that the RAM read of this pixel could not see yet.
    assign s1_src   = fwd_vld_q ? fwd_data_q : (touched_q[s1_bin_q] ? iRData : '0);
    assign s1_wdata = (s1_src == CntMax) ? CntMax : s1_src + CNT_W'(1);

`ifdef HISTO_CUM_EN
    logic              cum_busy_q, cum_busy_d;
    logic [BIN_AW-1:0] cum_idx_q, cum_idx_d;
    logic              cum_wr_q, cum_wr_d;
    logic [BIN_AW-1:0] cum_wr_idx_q, cum_wr_idx_d;
    logic [CNT_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cum_masked, sum_sat;
    logic [CNT_W:0]    sum_ext;

    assign rd_cum_sel = iRd_cum;
    assign cum_masked = touched_q[cum_wr_idx_q] ? iRData : '0;
    assign sum_ext    = {1'b0, sum_q} + {1'b0, cum_masked};
    assign sum_sat    = sum_ext[CNT_W] ? CntMax : sum_ext[CNT_W-1:0];
`else
    logic unused_rd_cum;
    assign unused_rd_cum = iRd_cum;
    assign rd_cum_sel    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        touched_d  = touched_q;
        total_d    = total_q;
        s1_vld_d   = 1'b0;
        s1_bin_d   = s1_bin_q;
        fwd_vld_d  = 1'b0;
        fwd_data_d = s1_wdata;
        rd_vld_d   = 1'b0;
        rd_bin_d   = rd_bin_q;
        rd_cum_d   = rd_cum_q;
        oRAddr     = '0;
        oWAddr     = '0;
        oWData     = '0;
        oWe        = 1'b0;
`ifdef HISTO_CUM_EN
        cum_busy_d   = cum_busy_q;
        cum_idx_d    = cum_idx_q;
        cum_wr_d     = 1'b0;
        cum_wr_idx_d = cum_wr_idx_q;
        sum_d        = sum_q;
`endif

        // The stage-1 write completes even on the cycle after the frame ends.
        if (s1_vld_q) begin
            oWe                 = 1'b1;
            oWAddr              = {1'b0, s1_bin_q};
            oWData              = s1_wdata;
            touched_d[s1_bin_q] = 1'b1;
        end

        case (state_q)
            StAccum: begin
                if (s0_go) begin
                    oRAddr    = {1'b0, iGrey};
                    s1_vld_d  = 1'b1;
                    s1_bin_d  = iGrey;
                    fwd_vld_d = s1_vld_q & (iGrey == s1_bin_q);
                    total_d   = (total_q == CntMax) ? CntMax : total_q + CNT_W'(1);
                end
                if (fval_fall) begin
`ifdef HISTO_CUM_EN
                    state_d    = StCum;
                    cum_busy_d = 1'b1;
                    cum_idx_d  = '0;
                    sum_d      = '0;
`else
                    state_d    = StReady;
`endif
                end
            end
`ifdef HISTO_CUM_EN
            StCum: begin
                if (cum_busy_q) begin
                    oRAddr       = {1'b0, cum_idx_q};
                    cum_wr_d     = 1'b1;
                    cum_wr_idx_d = cum_idx_q;
                    cum_idx_d    = cum_idx_q + BIN_AW'(1);
                    if (cum_idx_q == '1) begin
                        cum_busy_d = 1'b0;
                    end
                end
                // A new frame aborts the sweep; no cumulative write on the edge cycle either.
                if (cum_wr_q && !fval_rise) begin
                    sum_d  = sum_sat;
                    oWe    = 1'b1;
                    oWAddr = {1'b1, cum_wr_idx_q};
                    oWData = sum_sat;
                    if (cum_wr_idx_q == '1) begin
                        state_d = StReady;
                    end
                end
            end
`endif
            StReady: begin
                if (iRd_req && !fval_rise) begin
                    oRAddr   = {rd_cum_sel, iRd_bin};
                    rd_vld_d = 1'b1;
                    rd_bin_d = iRd_bin;
                    rd_cum_d = rd_cum_sel;
                end
            end
            default: ;
        endcase

        if (fval_rise) begin
            state_d   = StAccum;
            touched_d = '0;
            total_d   = '0;
            s1_vld_d  = 1'b0;
            fwd_vld_d = 1'b0;
        end
    end

    // The cumulative bank is fully rewritten by each sweep, so only histogram reads are masked.
    assign oRd_valid   = rd_vld_q;
    assign oRd_data    = (rd_vld_q && (rd_cum_q || touched_q[rd_bin_q])) ? iRData : '0;
    assign oHist_ready = (state_q == StReady) & ~fval_rise;
    assign oTotal      = total_q;

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= StIdle;
            fval_q     <= 1'b0;
            touched_q  <= '0;
            total_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_bin_q   <= '0;
            fwd_vld_q  <= 1'b0;
            fwd_data_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_bin_q   <= '0;
            rd_cum_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fval_q     <= iFval;
            touched_q  <= touched_d;
            total_q    <= total_d;
            s1_vld_q   <= s1_vld_d;
            s1_bin_q   <= s1_bin_d;
            fwd_vld_q  <= fwd_vld_d;
            fwd_data_q <= fwd_data_d;
            rd_vld_q   <= rd_vld_d;
            rd_bin_q   <= rd_bin_d;
            rd_cum_q   <= rd_cum_d;
        end
    end

`ifdef HISTO_CUM_EN
    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            cum_busy_q   <= 1'b0;
            cum_idx_q    <= '0;
            cum_wr_q     <= 1'b0;
            cum_wr_idx_q <= '0;
            sum_q        <= '0;
        end else begin
            cum_busy_q   <= cum_busy_d;
            cum_idx_q    <= cum_idx_d;
            cum_wr_q     <= cum_wr_d;
            cum_wr_idx_q <= cum_wr_idx_d;
            sum_q        <= sum_d;
        end
    end
`endif

endmodule
